ro_pair_sequencer: RTL
======================

# ro_pair_sequencer

Challenge sequencer and frequency comparator for the ring-oscillator PUF; sits directly upstream of the 4-to-16 RO-enable decoder. The block accepts an 8-bit challenge naming two of the 16 ring oscillators. It drives the decoder select with each index in turn and counts rising edges of the selected oscillator output over a fixed window. It then emits one response bit, set when oscillator A counted more edges than oscillator B.

## Interface

Parameters:
- SETTLE, 4: cycles the oscillator runs after selection before counting starts; minimum 3.
- WINDOW, 1024: cycles per counting window; minimum 1.
- CNT_W, 16: edge-counter width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only in IDLE.
- challenge  input  8  [7:4] = RO index A, [3:0] = RO index B; sampled on the accepting cycle.
- ro_in  input  1  muxed output of the selected oscillator; asynchronous to clk.
- ro_sel  output  4  oscillator index, to the decoder input.
- ro_en  output  1  oscillator enable; the decoder output is ANDed with this.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the result is valid.
- response  output  1  1 when count_a > count_b, otherwise 0.
- count_a  output  CNT_W  captured edge count for A.
- count_b  output  CNT_W  captured edge count for B.

## Operation

- States: IDLE, SETTLE_A, COUNT_A, SETTLE_B, COUNT_B, DONE.
- IDLE, start=1: latch challenge, clear count_a, count_b and response, then go to SETTLE_A. IDLE, start=0: stay.
- SETTLE_A: ro_sel=A, ro_en=1, edge counter held at 0. Lasts SETTLE cycles, then COUNT_A.
- COUNT_A: counter increments on each detected rising edge. Lasts WINDOW cycles. On exit, load the counter into count_a, then go to SETTLE_B.
- SETTLE_B and COUNT_B: same as the A phases with ro_sel=B. On exit from COUNT_B, load count_b, then go to DONE.
- DONE: ro_en=0, done=1, response = (count_a > count_b). Lasts 1 cycle, then IDLE.
- Edge detect:
  - ro_in passes through a 2-flop synchronizer, then a third delay flop.
  - An edge is detected when sync2 & ~sync3.
  - The synchronizer runs continuously. SETTLE ≥ 3 flushes the previous oscillator's samples.
- The counter saturates at 2^CNT_W−1 and never wraps.
- Tie (count_a == count_b) gives response 0. A == B is legal, with no special handling.
- start is ignored while busy. challenge changes outside the accepting cycle have no effect.
- In IDLE, ro_sel holds its last value and ro_en=0.
- Reset values: ro_sel=0, ro_en=0, busy=0, done=0, response=0, count_a=0, count_b=0, state=IDLE, synchronizer flops 0.
- Reset asserted mid-operation aborts immediately to the reset values above. No done is produced for the aborted challenge.

## Timing

- Cycle 0: start accepted in IDLE.
- Cycle 1: ro_en=1, ro_sel=A, busy=1.
- Cycles 1 .. SETTLE: SETTLE_A. Cycles SETTLE+1 .. SETTLE+WINDOW: COUNT_A.
- count_a is valid from cycle SETTLE+WINDOW+1, the first cycle of SETTLE_B, where ro_sel=B.
- done is high at cycle 2·(SETTLE+WINDOW)+1. response and count_b are valid from that cycle.
- response, count_a and count_b stay valid until the next accepted start.
- busy is high in the done cycle. The earliest next accept is the cycle after done.
- The 2-cycle synchronizer delay shifts the counted interval by 2 cycles. The shift is identical for A and B.

## Test plan

Bench parameters: SETTLE=4, WINDOW=64, CNT_W=16, unless a scenario overrides them. The bench oscillator model is phase-aligned with the start pulse; ro_in is driven by that model according to the selected ro_sel.
- Reset/idle: hold rst_n=0, then release with start=0 for 20 cycles -> all outputs remain at their reset values; busy=0, ro_en=0.
- Basic compare: challenge=8'h3A; RO 3 rising edge every 4 cycles, RO 10 every 6 cycles -> count_a=16±1, count_b=11±1, response=1. done at cycle 137 after accept. ro_sel=3 in cycles 1–68 and 10 in cycles 69–136.
- Reverse and tie: challenge=8'hA3 with the same oscillators -> response=0. Then challenge=8'h55 -> count_a==count_b, response=0.
- Saturation: override CNT_W=4; both ROs have a rising edge every 2 cycles -> count_a=count_b=15, response=0, no wrap.
- Start while busy: pulse start with challenge=8'hFF at cycle 30 of a run on 8'h3A -> ignored. Exactly one done, and the result matches 8'h3A. Start asserted in the cycle after done is accepted.
- Mid-run reset: assert rst_n=0 during COUNT_B -> next cycle ro_en=0, busy=0, counts=0, no done. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/ro_pair_sequencer.sv
// Ring-oscillator PUF pair sequencer: selects RO A then RO B, counts synchronized
// rising edges of each over a fixed window and reports whether A was faster.
module ro_pair_sequencer #(
  parameter int SETTLE = 4,
  parameter int WINDOW = 1024,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       challenge,
  input  logic             ro_in,
  output logic [3:0]       ro_sel,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  // state    | meaning
  // IDLE     | waiting for start, oscillators off, results held
  // SETTLE_A | RO A enabled, counter held at 0 while it settles
  // COUNT_A  | counting RO A rising edges for WINDOW cycles
  // SETTLE_B | RO B enabled, counter held at 0
  // COUNT_B  | counting RO B rising edges for WINDOW cycles
  // DONE     | one-cycle result strobe
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE_A,
    ST_COUNT_A,
    ST_SETTLE_B,
    ST_COUNT_B,
    ST_DONE
  } state_t;

  localparam int TMR_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_q;
  state_t           state_d;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;
  logic             tc;

  logic [3:0]       sel_b_q;
  logic             sync1;
  logic             sync2;
  logic             sync3;
  logic             ro_rise;
  logic             counting;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  assign tc      = (tmr_q == '0);
  assign ro_rise = sync2 & ~sync3;

  // Counter saturates instead of wrapping so a fast RO never looks slow.
  assign cnt_nxt = (ro_rise && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    ro_en    = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    counting = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = ST_SETTLE_A;
          tmr_d   = SETTLE_LD;
        end
      end
      ST_SETTLE_A: begin
        ro_en = 1'b1;
        if (tc) begin
          state_d = ST_COUNT_A;
          tmr_d   = WINDOW_LD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_COUNT_A: begin
        ro_en    = 1'b1;
        counting = 1'b1;
        if (tc) begin
          state_d = ST_SETTLE_B;
          tmr_d   = SETTLE_LD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_SETTLE_B: begin
        ro_en = 1'b1;
        if (tc) begin
          state_d = ST_COUNT_B;
          tmr_d   = WINDOW_LD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_COUNT_B: begin
        ro_en    = 1'b1;
        counting = 1'b1;
        if (tc) begin
          state_d = ST_DONE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Synchronizer runs continuously; SETTLE >= 3 flushes the previous RO's samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= ro_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sel_b_q  <= '0;
      ro_sel   <= '0;
      count_a  <= '0;
      count_b  <= '0;
      response <= 1'b0;
    end else begin
      cnt_q <= (counting && !tc) ? cnt_nxt : '0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            ro_sel   <= challenge[7:4];
            sel_b_q  <= challenge[3:0];
            count_a  <= '0;
            count_b  <= '0;
            response <= 1'b0;
          end
        end
        ST_COUNT_A: begin
          if (tc) begin
            count_a <= cnt_nxt;
            ro_sel  <= sel_b_q;
          end
        end
        ST_COUNT_B: begin
          if (tc) begin
            count_b  <= cnt_nxt;
            response <= (count_a > cnt_nxt);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
